// File: rtl/instruction_cache_pkg.sv
// instruction_cache_pkg: shared state encoding and default geometry for the instruction cache
package instruction_cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam int DEF_INDEX_BITS = 4;
    localparam int DEF_WORD_BITS  = 2;

    // Tag width is whatever remains of a 32-bit byte address above index, word and byte offset
    function automatic int tag_bits(input int index_bits, input int word_bits);
        return 32 - index_bits - word_bits - 2;
    endfunction

endpackage

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only instruction cache with word-serial line refill
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        clearIn,
    input  logic        fetchFlag,
    input  logic [31:0] fetchAddr,
    output logic        instOk,
    output logic [31:0] instOut,
    output logic        memFlag,
    output logic [31:0] memAddr,
    input  logic        memOk,
    input  logic [31:0] memData
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS, WORD_BITS);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;

    state_t state, state_next;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [31:0]           data_arr [LINES*WORDS];
    logic [WORD_BITS-1:0]  counter;
    logic [TAG_BITS-1:0]   line_tag;
    logic [INDEX_BITS-1:0] line_index;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [WORD_BITS-1:0]  req_word;
    logic                  flush, hit, accept, miss, word_done, last_done;
    logic                  unused_addr_lsb;

    assign req_tag         = fetchAddr[31 -: TAG_BITS];
    assign req_index       = fetchAddr[WORD_BITS+2 +: INDEX_BITS];
    assign req_word        = fetchAddr[2 +: WORD_BITS];
    assign unused_addr_lsb = ^fetchAddr[1:0];

    assign flush     = clearIn & readyIn;
    assign hit       = valid[req_index] && (tag_arr[req_index] == req_tag);
    assign accept    = (state == IDLE) && fetchFlag && !instOk;
    assign miss      = accept && !hit;
    assign word_done = (state == REFILL) && memOk;
    assign last_done = word_done && (&counter);

    // State register
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) state <= IDLE;
        else          state <= state_next;
    end

    // Next state: flush wins, a miss starts a refill, the last refill word returns to idle
    always_comb begin
        state_next = flush ? IDLE : miss ? REFILL : last_done ? IDLE : state;
    end

    // Memory request outputs; flag drops while memOk is high so the stale address is never re-accepted
    always_comb begin
        memFlag = (state == REFILL) && !memOk;
        memAddr = {line_tag, line_index, counter, 2'b00};
    end

    // Hit response, refill bookkeeping and valid bits
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            instOk     <= 1'b0;
            instOut    <= '0;
            counter    <= '0;
            valid      <= '0;
            line_tag   <= '0;
            line_index <= '0;
        end else if (flush) begin
            instOk  <= 1'b0;
            counter <= '0;
        end else begin
            instOk <= accept && hit;
            if (accept && hit) instOut <= data_arr[{req_index, req_word}];
            if (miss) begin
                counter           <= '0;
                line_tag          <= req_tag;
                line_index        <= req_index;
                valid[req_index]  <= 1'b0;
            end else if (word_done) begin
                counter <= counter + WORD_BITS'(1);
                if (last_done) valid[line_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone decide whether contents are usable
    always_ff @(posedge clockIn) begin
        if (word_done && !flush) data_arr[{line_index, counter}] <= memData;
        if (last_done && !flush) tag_arr[line_index] <= line_tag;
    end

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed self-checking bench for instruction_cache
module tb_instruction_cache;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        readyIn;
    logic        clearIn;
    logic        fetchFlag;
    logic [31:0] fetchAddr;
    logic        instOk;
    logic [31:0] instOut;
    logic        memFlag;
    logic [31:0] memAddr;
    logic        memOk;
    logic [31:0] memData;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_cache dut (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .readyIn  (readyIn),
        .clearIn  (clearIn),
        .fetchFlag(fetchFlag),
        .fetchAddr(fetchAddr),
        .instOk   (instOk),
        .instOut  (instOut),
        .memFlag  (memFlag),
        .memAddr  (memAddr),
        .memOk    (memOk),
        .memData  (memData)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clockIn);
    endtask

    // Backing memory contents: upper half is the address, lower half its complement
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Controller stand-in: wait for a request, check it, answer two cycles later
    task automatic serve_word(input logic [31:0] exp_addr, input string tag);
        int n = 0;
        while (!memFlag && n < 20) begin
            tick();
            n++;
        end
        check({tag, " flag"}, {31'd0, memFlag}, 32'd1);
        check({tag, " addr"}, memAddr, exp_addr);
        tick();
        check({tag, " hold"}, memAddr, exp_addr);
        memOk   = 1'b1;
        memData = mem_word(exp_addr);
        #1;
        check({tag, " drop"}, {31'd0, memFlag}, 32'd0);
        tick();
        memOk   = 1'b0;
        memData = '0;
    endtask

    task automatic finish_miss(input logic [31:0] exp_inst, input string tag);
        check({tag, " idle"}, {31'd0, memFlag}, 32'd0);
        check({tag, " early"}, {31'd0, instOk}, 32'd0);
        tick();
        check({tag, " ok"}, {31'd0, instOk}, 32'd1);
        check({tag, " inst"}, instOut, exp_inst);
        fetchFlag = 1'b0;
        tick();
        check({tag, " pulse"}, {31'd0, instOk}, 32'd0);
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] exp_inst, input string tag);
        logic [31:0] base;
        base      = {addr[31:4], 4'h0};
        fetchFlag = 1'b1;
        fetchAddr = addr;
        for (int i = 0; i < 4; i++) serve_word(base + 32'(i * 4), tag);
        finish_miss(exp_inst, tag);
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp_inst, input string tag);
        fetchFlag = 1'b1;
        fetchAddr = addr;
        tick();
        check({tag, " ok"}, {31'd0, instOk}, 32'd1);
        check({tag, " inst"}, instOut, exp_inst);
        check({tag, " nomem"}, {31'd0, memFlag}, 32'd0);
        fetchFlag = 1'b0;
        tick();
        check({tag, " pulse"}, {31'd0, instOk}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetIn   = 1'b0;
        readyIn   = 1'b1;
        clearIn   = 1'b0;
        fetchFlag = 1'b0;
        fetchAddr = '0;
        memOk     = 1'b0;
        memData   = '0;
        tick();
        tick();
        check("reset instOk", {31'd0, instOk}, 32'd0);
        check("reset instOut", instOut, 32'd0);
        check("reset memFlag", {31'd0, memFlag}, 32'd0);
        resetIn = 1'b1;
        tick();

        fetch_miss(32'h0000_0000, 32'h0000_FFFF, "cold miss 0x0");
        fetch_hit(32'h0000_0008, 32'h0008_FFF7, "hit 0x8");

        fetch_miss(32'h0000_0100, 32'h0100_FEFF, "evict 0x100");
        fetch_hit(32'h0000_0104, 32'h0104_FEFB, "hit 0x104");
        fetch_miss(32'h0000_0000, 32'h0000_FFFF, "re-miss 0x0");

        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0200;
        serve_word(32'h0000_0200, "abort w0");
        serve_word(32'h0000_0204, "abort w1");
        clearIn   = 1'b1;
        fetchFlag = 1'b0;
        tick();
        clearIn = 1'b0;
        check("flush memFlag", {31'd0, memFlag}, 32'd0);
        check("flush instOk", {31'd0, instOk}, 32'd0);
        tick();
        check("flush settled memFlag", {31'd0, memFlag}, 32'd0);
        check("flush settled instOk", {31'd0, instOk}, 32'd0);
        fetch_miss(32'h0000_0000, 32'h0000_FFFF, "aborted line invalid");
        fetch_miss(32'h0000_0208, 32'h0208_FDF7, "refetch 0x208");

        memOk   = 1'b1;
        memData = 32'hDEAD_BEEF;
        tick();
        memOk   = 1'b0;
        memData = '0;
        check("stray instOk", {31'd0, instOk}, 32'd0);
        check("stray memFlag", {31'd0, memFlag}, 32'd0);
        fetch_hit(32'h0000_0200, 32'h0200_FDFF, "stray no write");

        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0300;
        serve_word(32'h0000_0300, "noready w0");
        clearIn = 1'b1;
        readyIn = 1'b0;
        serve_word(32'h0000_0304, "noready w1");
        clearIn = 1'b0;
        readyIn = 1'b1;
        serve_word(32'h0000_0308, "noready w2");
        serve_word(32'h0000_030C, "noready w3");
        finish_miss(32'h0300_FCFF, "clear without ready");

        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0304;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("held fetch cycle %0d", i), {31'd0, instOk}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("held fetch inst", instOut, 32'h0304_FCFB);
        fetchFlag = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
